// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rle_pkg;

   localparam int SYM_W = 7;
   localparam logic [SYM_W-1:0] MAX_RUN  = 7'd127;
   localparam logic [SYM_W-1:0] IDLE_SYM = 7'd0;

   // data[7]=1 -> count word (data[6:0] = run length)
   // data[7]=0 -> literal word (data[6:0] = symbol)
   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } out_st;

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      REPEAT
   } state_t;

endpackage

// File: rtl/run_length_encoder_moore.sv
// Streaming run-length encoder: literal per run, plus total length when N>=2.
// Latency: literal 1 cycle after first symbol (2 if deferred); count 1 cycle after run end.
// Backpressure: none; consumer must accept every valid cycle.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset
//   dataIn  - 7-bit symbol sampled every cycle, 0 = idle
//   dataOut - registered {data[7:0], valid} word stream
module run_length_encoder_moore
   import rle_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [SYM_W-1:0] dataIn,
   output out_st            dataOut
);

   state_t           State, state_nxt;
   logic [SYM_W-1:0] count, count_nxt;
   logic [SYM_W-1:0] sym, sym_nxt;
   logic             pend_vld, pend_vld_nxt;
   logic [7:0]       pend_dat, pend_dat_nxt;
   out_st            out_nxt;

   logic       in_idle;
   logic       run_open;
   logic       same_sym;
   logic       at_max;
   logic       close_run;
   logic       start_run;
   logic       emit_cnt;
   logic [7:0] cnt_word;
   logic [7:0] lit_word;

   // Run boundary decode. A 128th identical symbol both closes the
   // current run and opens a fresh one, which keeps count from wrapping.
   assign in_idle   = (dataIn == IDLE_SYM);
   assign run_open  = (State != IDLE);
   assign same_sym  = (dataIn == sym);
   assign at_max    = (count == MAX_RUN);
   assign close_run = run_open && (in_idle || !same_sym || at_max);
   assign start_run = !in_idle && (!run_open || !same_sym || at_max);
   // Only runs of length >= 2 (REPEAT) carry a count word.
   assign emit_cnt  = close_run && (State == REPEAT);
   assign cnt_word  = {1'b1, count};
   assign lit_word  = {1'b0, dataIn};

   always_comb begin
      state_nxt    = State;
      count_nxt    = count;
      sym_nxt      = sym;
      out_nxt      = '0;
      pend_vld_nxt = 1'b0;
      pend_dat_nxt = 8'h00;

      // Word arbitration: pending literal, then closing count, then new
      // literal. The single loser (if any) is parked in the pending slot.
      if (pend_vld) begin
         out_nxt = '{data: pend_dat, valid: 1'b1};
         if (emit_cnt) begin
            pend_vld_nxt = 1'b1;
            pend_dat_nxt = cnt_word;
         end else if (start_run) begin
            pend_vld_nxt = 1'b1;
            pend_dat_nxt = lit_word;
         end
      end else if (emit_cnt) begin
         out_nxt = '{data: cnt_word, valid: 1'b1};
         if (start_run) begin
            pend_vld_nxt = 1'b1;
            pend_dat_nxt = lit_word;
         end
      end else if (start_run) begin
         out_nxt = '{data: lit_word, valid: 1'b1};
      end

      // Run tracking.
      if (in_idle) begin
         state_nxt = IDLE;
         count_nxt = '0;
      end else if (start_run) begin
         state_nxt = FIRST;
         count_nxt = 7'd1;
         sym_nxt   = dataIn;
      end else begin
         state_nxt = REPEAT;
         count_nxt = count + 7'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         State    <= IDLE;
         count    <= '0;
         sym      <= '0;
         pend_vld <= 1'b0;
         pend_dat <= 8'h00;
         dataOut  <= '0;
      end else begin
         State    <= state_nxt;
         count    <= count_nxt;
         sym      <= sym_nxt;
         pend_vld <= pend_vld_nxt;
         pend_dat <= pend_dat_nxt;
         dataOut  <= out_nxt;
      end
   end

   // Three simultaneous words would need a second pending slot; the run
   // structure guarantees this never happens.
   pend_overflow_chk: assert property (
      @(posedge clock) disable iff (reset) !(pend_vld && emit_cnt && start_run)
   );

endmodule

// File: tb/tb_run_length_encoder_moore.sv
module tb_run_length_encoder_moore;
   import rle_pkg::*;

   logic       clock;
   logic       reset;
   logic [6:0] dataIn;
   out_st      dataOut;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] words[$];
   logic [7:0] exp_q[$];

   run_length_encoder_moore dut (
      .clock  (clock),
      .reset  (reset),
      .dataIn (dataIn),
      .dataOut(dataOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one symbol, let it be sampled, then observe the output #1 later.
   task automatic step(input logic [6:0] s);
      dataIn = s;
      @(posedge clock);
      #1;
      if (dataOut.valid) words.push_back(dataOut.data);
   endtask

   task automatic step_chk(input string tag, input logic [6:0] s,
                           input logic ev, input logic [7:0] ed);
      step(s);
      check(tag, {23'd0, dataOut.data, dataOut.valid}, {23'd0, ed, ev});
   endtask

   task automatic compare_words(input string tag);
      check({tag, "_n"}, words.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < words.size(); i++)
         check($sformatf("%s_w%0d", tag, i), {24'd0, words[i]}, {24'd0, exp_q[i]});
   endtask

   initial begin
      reset  = 1'b1;
      dataIn = 7'd0;

      // Reset state
      repeat (3) step(7'd0);
      check("rst_out", {23'd0, dataOut}, 32'd0);
      check("rst_state", 32'(dut.State), 32'(IDLE));
      check("rst_count", {25'd0, dut.count}, 32'd0);
      reset = 1'b0;
      step_chk("idle_a", 7'd0, 1'b0, 8'h00);
      step_chk("idle_b", 7'd0, 1'b0, 8'h00);

      // 55, 75x3, 28: exact per-cycle timing, count before deferred literal
      step_chk("ex_c1", 7'd55, 1'b1, 8'h37);
      check("ex_first", 32'(dut.State), 32'(FIRST));
      step_chk("ex_c2", 7'd75, 1'b1, 8'h4B);
      step_chk("ex_c3", 7'd75, 1'b0, 8'h00);
      step_chk("ex_c4", 7'd75, 1'b0, 8'h00);
      check("ex_repeat", 32'(dut.State), 32'(REPEAT));
      step_chk("ex_c5", 7'd28, 1'b1, 8'h83);
      step_chk("ex_c6", 7'd0, 1'b1, 8'h1C);
      step_chk("ex_c7", 7'd0, 1'b0, 8'h00);

      // Alternating singles: one literal per cycle, no counts, nothing pending
      step_chk("alt_28", 7'd28, 1'b1, 8'h1C);
      check("alt_p0", {31'd0, dut.pend_vld}, 32'd0);
      step_chk("alt_122", 7'd122, 1'b1, 8'h7A);
      check("alt_p1", {31'd0, dut.pend_vld}, 32'd0);
      step_chk("alt_88", 7'd88, 1'b1, 8'h58);
      check("alt_p2", {31'd0, dut.pend_vld}, 32'd0);
      step_chk("alt_end", 7'd0, 1'b0, 8'h00);

      // 08 x270 then 111: split at 127
      words.delete();
      for (int i = 1; i <= 270; i++) begin
         step(7'd8);
         if (i == 127) check("long_c127", {25'd0, dut.count}, 32'd127);
         if (i == 128) check("long_c128", {25'd0, dut.count}, 32'd1);
         if (i == 270) check("long_c270", {25'd0, dut.count}, 32'd16);
      end
      step(7'd111);
      step(7'd0);
      step(7'd0);
      exp_q = '{8'h08, 8'hFF, 8'h08, 8'hFF, 8'h08, 8'h90, 8'h6F};
      compare_words("long");

      // 44x23, 03x4, 0x10
      words.delete();
      repeat (23) step(7'd44);
      repeat (4) step(7'd3);
      repeat (10) step(7'd0);
      exp_q = '{8'h2C, 8'h97, 8'h03, 8'h84};
      compare_words("mix");
      check("mix_state", 32'(dut.State), 32'(IDLE));
      check("mix_count", {25'd0, dut.count}, 32'd0);
      check("mix_out", {23'd0, dataOut}, 32'd0);

      // Reset in the middle of a 03 run
      words.delete();
      repeat (3) step(7'd3);
      reset = 1'b1;
      step(7'd3);
      check("rr_out", {23'd0, dataOut}, 32'd0);
      check("rr_state", 32'(dut.State), 32'(IDLE));
      check("rr_count", {25'd0, dut.count}, 32'd0);
      reset = 1'b0;
      words.delete();
      repeat (3) step(7'd0);
      check("rr_nostale", words.size(), 32'd0);

      // Reset while a literal is pending
      step_chk("rp_lit", 7'd5, 1'b1, 8'h05);
      step(7'd5);
      step_chk("rp_cnt", 7'd9, 1'b1, 8'h82);
      check("rp_pend", {31'd0, dut.pend_vld}, 32'd1);
      reset = 1'b1;
      step(7'd9);
      check("rp_out", {23'd0, dataOut}, 32'd0);
      check("rp_pclr", {31'd0, dut.pend_vld}, 32'd0);
      check("rp_state", 32'(dut.State), 32'(IDLE));
      check("rp_count", {25'd0, dut.count}, 32'd0);
      reset = 1'b0;
      words.delete();
      repeat (3) step(7'd0);
      check("rp_nostale", words.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
